// File: rtl/bs_pkg.sv
// bs_pkg: scheme codes, scanner states and ROM size thresholds shared by the scan controller.
package bs_pkg;
  typedef enum logic [2:0] {
    BS_NONE = 3'd0,
    BS_F8   = 3'd1,
    BS_F6   = 3'd2,
    BS_F4   = 3'd3,
    BS_E0   = 3'd4,
    BS_FE   = 3'd5
  } bs_scheme_e;

  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DECIDE, ST_DONE} bs_state_e;

  localparam logic [31:0] LAST_4K  = 32'h0FFF;
  localparam logic [31:0] LAST_8K  = 32'h1FFF;
  localparam logic [31:0] LAST_16K = 32'h3FFF;

  // Only 8K images are ambiguous; E0 wins over FE when both signatures were seen.
  function automatic bs_scheme_e pick_scheme(input logic [31:0] last, input logic e0, input logic fe);
    return last <= LAST_4K ? BS_NONE :
           last <= LAST_8K ? (e0 ? BS_E0 : fe ? BS_FE : BS_F8) :
           last <= LAST_16K ? BS_F6 : BS_F4;
  endfunction
endpackage

// File: rtl/bs_rd_pipe.sv
// bs_rd_pipe: delays read valid/address by the ROM read latency so they line up with rom_rdata.
module bs_rd_pipe #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign addr_o = addr_q[DEPTH-1];
endmodule

// File: rtl/bs_scan_ctrl.sv
// bs_scan_ctrl: post-load ROM scanner feeding the E0/FE signature detectors and choosing the bank-switch scheme.
// Optional SuperChip RAM detection is compiled in when BS_SUPERCHIP_EN is defined.
module bs_scan_ctrl
  import bs_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int RD_LATENCY  = 1,
  parameter int DET_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] rom_last,
  input  logic              rom_gnt,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic              det_ena,
  output logic [ADDR_W-1:0] det_addr,
  output logic [7:0]        det_data,
  input  logic              hit_e0,
  input  logic              hit_fe,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [2:0]        scheme,
  output logic              sc
);
  localparam int DRAIN_CYC = RD_LATENCY + DET_LATENCY;

  bs_state_e         st_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [2:0]        drn_q, scheme_q;
  logic              e0_q, fe_q, busy_q, done_q, hold_q, launch;

  assign launch   = (st_q == ST_IDLE || st_q == ST_DONE) && start;
  assign cnt_d    = cnt_q + ADDR_W'(1);
  assign rom_rd   = st_q == ST_SCAN && rom_gnt;
  assign rom_addr = cnt_q;
  assign det_data = det_ena ? rom_rdata : 8'h00;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cpu_hold = hold_q;
  assign scheme   = scheme_q;

  bs_rd_pipe #(.ADDR_W(ADDR_W), .DEPTH(RD_LATENCY)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .vld_i  (rom_rd),
    .addr_i (cnt_q),
    .vld_o  (det_ena),
    .addr_o (det_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      drn_q    <= '0;
      e0_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= 1'b1;
      scheme_q <= BS_NONE;
    end else begin
      // Detector hits trail the last byte by the full drain window, so keep sampling through DRAIN.
      if (st_q == ST_SCAN || st_q == ST_DRAIN) begin
        e0_q <= e0_q | hit_e0;
        fe_q <= fe_q | hit_fe;
      end
      case (st_q)
        ST_IDLE, ST_DONE: if (launch) begin
          st_q   <= ST_SCAN;
          cnt_q  <= '0;
          e0_q   <= 1'b0;
          fe_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b1;
          hold_q <= 1'b1;
        end
        ST_SCAN: if (rom_gnt) begin
          cnt_q <= cnt_d;
          if (cnt_q == rom_last) begin
            st_q  <= ST_DRAIN;
            drn_q <= '0;
          end
        end
        ST_DRAIN: begin
          drn_q <= drn_q + 3'd1;
          if (drn_q == 3'(DRAIN_CYC - 1)) st_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          scheme_q <= pick_scheme(32'(rom_last), e0_q, fe_q);
          st_q     <= ST_DONE;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          hold_q   <= 1'b0;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BS_SUPERCHIP_EN
  logic [7:0] ref_q;
  logic       eq_q, sc_q;

  // Bytes arrive in address order, so address 0 sets the reference before the rest of the first page.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q <= '0;
      eq_q  <= 1'b0;
      sc_q  <= 1'b0;
    end else if (launch) begin
      eq_q <= 1'b1;
      sc_q <= 1'b0;
    end else begin
      if (det_ena && det_addr[ADDR_W-1:8] == '0) begin
        if (det_addr[7:0] == 8'h00) ref_q <= det_data;
        else if (det_data != ref_q) eq_q <= 1'b0;
      end
      if (st_q == ST_DECIDE)
        sc_q <= eq_q && (ref_q == 8'h00 || ref_q == 8'hFF) && 32'(rom_last) >= LAST_8K;
    end
  end

  assign sc = sc_q;
`else
  assign sc = 1'b0;
`endif
endmodule

// File: tb/tb_bs_scan_ctrl.sv
// tb_bs_scan_ctrl: table-driven and randomized checks of bs_scan_ctrl against a ROM model and a scheme reference.
module tb_bs_scan_ctrl;
  import bs_pkg::*;
  localparam int AW = 15, RDL = 1, DETL = 2, L = RDL + DETL, NO = -100000;
`ifdef BS_SUPERCHIP_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic clk = 0, reset = 0, start = 0, rom_gnt = 0, hit_e0 = 0, hit_fe = 0;
  logic [AW-1:0] rom_last = '0, rom_addr, det_addr;
  logic [7:0] rom_rdata, det_data;
  logic rom_rd, det_ena, cpu_hold, busy, done, sc;
  logic [2:0] scheme;
  int tests = 0, fails = 0, cur = 0;
  int rd_cnt, rd_bad, det_cnt, det_bad;
  bit mon_en = 0;
  logic [7:0] rom [2**AW];
  logic [7:0] rpipe [RDL];

  always #5 clk = ~clk;

  bs_scan_ctrl #(.ADDR_W(AW), .RD_LATENCY(RDL), .DET_LATENCY(DETL)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_last(rom_last), .rom_gnt(rom_gnt),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .det_ena(det_ena),
    .det_addr(det_addr), .det_data(det_data), .hit_e0(hit_e0), .hit_fe(hit_fe),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .scheme(scheme), .sc(sc)
  );

  // Synchronous ROM with RDL cycles of read latency
  always @(posedge clk) begin
    rpipe[0] <= rom_rd ? rom[rom_addr] : 8'h5A;
    for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_rdata = rpipe[RDL-1];

  // Reads must be 0,1,2,... only when granted; detector bytes must follow in order with ROM contents
  always @(negedge clk) if (mon_en) begin
    if (rom_rd) begin
      if (int'(rom_addr) != rd_cnt || !rom_gnt) rd_bad++;
      rd_cnt++;
    end
    if (det_ena) begin
      if (int'(det_addr) != det_cnt || det_data != rom[det_addr]) det_bad++;
      det_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL [%0d] %s: got %0d, expected %0d", cur, nm, act, exp);
    end
  endtask

  function automatic int ref_scheme(input int last, input bit e0, input bit fe);
    int bytes = last + 1;
    if (bytes <= 4096) return int'(BS_NONE);
    if (bytes <= 8192) return e0 ? int'(BS_E0) : fe ? int'(BS_FE) : int'(BS_F8);
    if (bytes <= 16384) return int'(BS_F6);
    return int'(BS_F4);
  endfunction

  function automatic int ref_sc(input int last);
    if (!SC_EN || last + 1 < 8192) return 0;
    for (int i = 1; i < 256; i++) if (rom[i] != rom[0]) return 0;
    return (rom[0] == 8'h00 || rom[0] == 8'hFF) ? 1 : 0;
  endfunction

  task automatic chk_rst();
    chk("rst_rom_rd", int'(rom_rd), 0);
    chk("rst_det_ena", int'(det_ena), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sc", int'(sc), 0);
    chk("rst_scheme", int'(scheme), int'(BS_NONE));
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_det_addr", int'(det_addr), 0);
    chk("rst_det_data", int'(det_data), 0);
    chk("rst_cpu_hold", int'(cpu_hold), 1);
  endtask

  // mode: 0 grant always, 1 grant on odd cycles, 2 random grant. e0_c/fe_c: absolute hit cycle (-1 none).
  // exp_sch/exp_sc < 0 selects the reference model.
  task automatic scan(input int last, input int mode, input int e0_c, input int fe_c, input bit rs,
                      input int fill, input int exp_sch, input int exp_sc);
    int n = last + 1, grants = 0, t_last = -1, cyc = 0, done_c = -1, limit = 4 * (last + 1) + 40;
    bit bh_ok = 1, e0s, fes;
    for (int i = 0; i < 2**AW; i++) rom[i] = 8'($urandom);
    if (fill != 0) for (int i = 0; i < 256; i++) rom[i] = (fill == 3) ? 8'h00 : 8'hFF;
    if (fill == 2) rom[8'h80] = 8'hFE;
    rom_last = AW'(last);
    rd_cnt = 0; rd_bad = 0; det_cnt = 0; det_bad = 0; mon_en = 1;
    @(posedge clk); #1 start = 1; rom_gnt = 0; hit_e0 = 0; hit_fe = 0;
    while (done_c < 0 && cyc < limit) begin
      @(posedge clk); #1 cyc++;
      start = rs && (t_last < 0 || cyc <= t_last + L + 1) && $urandom_range(0, 7) == 0;
      rom_gnt = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      hit_e0 = cyc == e0_c;
      hit_fe = cyc == fe_c;
      if (rom_gnt && grants < n) begin
        grants++;
        if (grants == n) t_last = cyc;
      end
      @(negedge clk);
      if (done) done_c = cyc;
      else if (!busy || !cpu_hold) bh_ok = 0;
    end
    e0s = e0_c >= 1 && t_last >= 0 && e0_c <= t_last + L;
    fes = fe_c >= 1 && t_last >= 0 && fe_c <= t_last + L;
    chk("done_cycle", done_c, t_last < 0 ? -2 : t_last + L + 2);
    chk("scheme", int'(scheme), exp_sch < 0 ? ref_scheme(last, e0s, fes) : exp_sch);
    chk("sc", int'(sc), exp_sc < 0 ? ref_sc(last) : exp_sc);
    chk("rd_count", rd_cnt, n);
    chk("rd_order", rd_bad, 0);
    chk("det_count", det_cnt, n);
    chk("det_seq", det_bad, 0);
    chk("busy_hold_during_scan", int'(bh_ok), 1);
    chk("busy_hold_at_done", int'({busy, cpu_hold}), 0);
    mon_en = 0;
    @(posedge clk); #1 start = 0; rom_gnt = 0; hit_e0 = 0; hit_fe = 0;
  endtask

  typedef struct {
    int last; int mode; int e0_off; int fe_off; int fill; int sch; bit sc1;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{32'h0FFF, 0, NO,    NO,    1, int'(BS_NONE), 1'b0};
    tbl[1] = '{32'h1FFF, 0, L,     NO,    1, int'(BS_E0),   1'b1};
    tbl[2] = '{32'h1FFF, 0, -2000, L,     2, int'(BS_E0),   1'b0};
    tbl[3] = '{32'h1FFF, 0, NO,    1,     3, int'(BS_FE),   1'b1};
    tbl[4] = '{32'h1000, 0, NO,    L + 1, 0, int'(BS_F8),   1'b0};
    tbl[5] = '{32'h3FFF, 0, -5,    NO,    3, int'(BS_F6),   1'b1};
    tbl[6] = '{32'h4000, 0, NO,    2,     1, int'(BS_F4),   1'b1};
    tbl[7] = '{32'h00FF, 1, NO,    NO,    0, int'(BS_NONE), 1'b0};
    tbl[8] = '{32'h0000, 0, NO,    NO,    0, int'(BS_NONE), 1'b0};
    repeat (3) @(posedge clk);
    #1 chk_rst();
    reset = 1;
    for (int v = 0; v < 9; v++) begin
      cur = v;
      scan(tbl[v].last, tbl[v].mode,
           tbl[v].e0_off == NO ? -1 : tbl[v].last + 1 + tbl[v].e0_off,
           tbl[v].fe_off == NO ? -1 : tbl[v].last + 1 + tbl[v].fe_off,
           1'b0, tbl[v].fill, tbl[v].sch, int'(SC_EN && tbl[v].sc1));
    end
    for (int r = 0; r < 12; r++) begin
      int last = $urandom_range(0, 63);
      cur = 50 + r;
      scan(last, 2, $urandom_range(1, last + 20), $urandom_range(1, last + 20), 1'b1, 0, -1, -1);
    end
    // Abort an 8K scan that has already latched an E0 hit, then rescan with no hits
    cur = 100;
    rom_last = AW'(32'h1FFF);
    @(posedge clk); #1 start = 1; rom_gnt = 1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1 start = 0; hit_e0 = c == 5;
    end
    #2 reset = 0;
    #1 chk_rst();
    @(posedge clk); #1 reset = 1; hit_e0 = 0; rom_gnt = 0;
    cur = 101;
    scan(32'h1000, 0, -1, -1, 1'b0, 0, int'(BS_F8), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
